// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall/flush sequencer for the five-stage core
module stall_ctrl #(
  parameter int EX_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_stallreq_i,
  input  logic                ex_start_i,
  input  logic [EX_CNT_W-1:0] ex_cycles_i,
  input  logic                flush_req_i,
  input  logic [31:0]         flush_pc_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic [31:0]         new_pc_o,
  output logic                ex_done_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE, EX_WAIT, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [EX_CNT_W-1:0] cnt_q, cnt_d, start_cnt;
  logic [31:0]         new_pc_q, new_pc_d;
  logic                flush_q, flush_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ex_stall;
  logic [5:0]          stall_raw;

  // The start cycle itself is the first stall cycle, so N stalls need N-1 counts left.
  assign start_cnt = (ex_cycles_i == '0) ? '0 : ex_cycles_i - EX_CNT_W'(1);

  always_comb begin
    ex_stall  = (state_q == EX_WAIT && cnt_q != '0) ||
                (state_q != FLUSH && ex_start_i && ex_cycles_i != '0);
    stall_raw = 6'b000000;
    if (flush_req_i || state_q == FLUSH)
      stall_raw = 6'b000000;
    else if (ex_stall)
      stall_raw = 6'b001111;
    else if (id_stallreq_i)
      stall_raw = 6'b000111;
  end

  assign stall_o = rst ? stall_raw : 6'b000000;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = flush_req_i ? flush_pc_i : new_pc_q;
    if (flush_req_i) begin
      state_d = FLUSH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_start_i) begin
            state_d = EX_WAIT;
            cnt_d   = start_cnt;
          end
        end
        EX_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - EX_CNT_W'(1);
          end else if (ex_start_i) begin
            cnt_d = start_cnt;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    flush_d = (state_d == FLUSH);
    done_d  = (state_d == EX_WAIT) && (cnt_d == '0);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      new_pc_q <= '0;
      flush_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      new_pc_q <= new_pc_d;
      flush_q  <= flush_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign flush_o   = flush_q;
  assign new_pc_o  = new_pc_q;
  assign ex_done_o = done_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - scoreboard bench for stall_ctrl with a cycle-level reference model
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_stallreq_i = 1'b0;
  logic        ex_start_i = 1'b0;
  logic [5:0]  ex_cycles_i = '0;
  logic        flush_req_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        ex_done_o;
  logic        busy_o;

  stall_ctrl #(.EX_CNT_W(6)) dut (
    .clk(clk), .rst(rst), .id_stallreq_i(id_stallreq_i), .ex_start_i(ex_start_i),
    .ex_cycles_i(ex_cycles_i), .flush_req_i(flush_req_i), .flush_pc_i(flush_pc_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .ex_done_o(ex_done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model: an op in flight is remembered as the absolute cycle its result lands.
  int          cyc = 0;
  bit          m_flush = 0;
  bit          m_op = 0;
  int          m_done_cyc = 0;
  logic [31:0] m_pc = '0;

  task automatic step(input bit r, input bit id, input bit st, input int n,
                      input bit fr, input logic [31:0] pc);
    exp_t e;
    bit   stalling;
    @(posedge clk);
    #1;
    rst = r; id_stallreq_i = id; ex_start_i = st; ex_cycles_i = 6'(n);
    flush_req_i = fr; flush_pc_i = pc;
    e.cyc = cyc;
    if (!r) begin
      m_flush = 0; m_op = 0; m_pc = '0;
      e.stall = '0; e.flush = 0; e.pc = '0; e.done = 0; e.busy = 0;
    end else begin
      stalling = m_op && (cyc < m_done_cyc);
      e.flush = m_flush;
      e.pc    = m_pc;
      e.done  = m_op && (cyc == m_done_cyc);
      e.busy  = m_flush || m_op;
      if (fr || m_flush)                           e.stall = 6'b000000;
      else if (stalling || (st && n != 0))         e.stall = 6'b001111;
      else if (id)                                 e.stall = 6'b000111;
      else                                         e.stall = 6'b000000;
      if (fr) begin
        m_flush = 1; m_op = 0; m_pc = pc;
      end else if (m_flush) begin
        m_flush = 0;
      end else if (stalling) begin
        // op still counting; a new start is ignored
      end else if (st) begin
        m_op = 1; m_done_cyc = cyc + ((n == 0) ? 1 : n);
      end else begin
        m_op = 0;
      end
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_o",   32'(stall_o),   32'(e.stall), e.cyc);
      check("flush_o",   32'(flush_o),   32'(e.flush), e.cyc);
      check("new_pc_o",  new_pc_o,       e.pc,         e.cyc);
      check("ex_done_o", 32'(ex_done_o), 32'(e.done),  e.cyc);
      check("busy_o",    32'(busy_o),    32'(e.busy),  e.cyc);
    end
  end

  initial begin
    // Reset held with every request asserted
    for (int i = 0; i < 3; i++) step(0, 1, 1, 5, 1, 32'hDEADBEEF);
    idle_steps(2);
    // Load-use for two cycles
    step(1, 1, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0); idle_steps(2);
    // N=5 with load-use held throughout
    step(1, 1, 1, 5, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, 0);
    idle_steps(2);
    // N=0, N=1, N=63
    step(1, 0, 1, 0, 0, 0); idle_steps(3);
    step(1, 0, 1, 1, 0, 0); idle_steps(3);
    step(1, 0, 1, 63, 0, 0); idle_steps(66);
    // Back-to-back: N=3 then restart N=2 on the done cycle
    step(1, 0, 1, 3, 0, 0); idle_steps(2); step(1, 0, 1, 2, 0, 0); idle_steps(4);
    // Flush abort of an N=10 op
    step(1, 0, 1, 10, 0, 0); idle_steps(2); step(1, 0, 0, 0, 1, 32'hBFC00380); idle_steps(14);
    // Flush together with a start, and a repeated flush
    step(1, 1, 1, 4, 1, 32'h1234_5678); step(1, 1, 1, 4, 1, 32'h0000_0040); idle_steps(6);
    // Reset mid-op
    step(1, 0, 1, 8, 0, 0); step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0); idle_steps(12);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, id, st, fr;
      int n;
      r  = ($urandom_range(0, 199) != 0);
      id = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) == 0);
      fr = ($urandom_range(0, 24) == 0);
      n  = ($urandom_range(0, 19) == 0) ? 63 : $urandom_range(0, 8);
      step(r, id, st, n, fr, $urandom);
    end
    idle_steps(2);
    repeat (3) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
